yuv422_to_rgb: RTL and testbench

- Display-side counterpart of the video-in RGB→YCbCr 4:2:2 path.
- Takes 8-bit Y plus interleaved Cb/Cr (4:2:2) with HS/VS/DE.
- Upsamples chroma to 4:4:4, converts BT.601 limited-range YCbCr to 8-bit RGB, and realigns syncs with the pixel data.
- Sits between the frame-buffer read side and the video output/encoder.

---
 rtl/yuv422_to_rgb.sv | 159 +++++++++++++++
 tb/tb_yuv422_to_rgb.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yuv422_to_rgb.sv
// yuv422_to_rgb: 4:2:2 YCbCr (BT.601 limited range) to 8-bit RGB for the display path.
// Chroma is upsampled by pair replication, the colour matrix is applied in fixed point
// (x256), and hs/vs/de ride a matching delay line so everything leaves 5 cycles later.
module yuv422_to_rgb #(
  parameter bit C_FIRST_CB = 1'b1
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       i_hs,
  input  logic       i_vs,
  input  logic       i_de,
  input  logic [7:0] i_y,
  input  logic [7:0] i_c,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_de,
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b
);

  // Chroma phase: 0 means the next DE pixel is the even (first) member of a pair.
  logic ph_q, ph_d;

  // Sync delay lines; bit k holds the value for pipeline stage k+1.
  logic [4:0] hs_q, hs_d, vs_q, vs_d, de_q, de_d;

  // Stage 1: raw sample plus its position inside the chroma pair.
  logic [7:0] y1_q, y1_d, c1_q, c1_d;
  logic       even1_q, even1_d;

  // Stage 2: full 4:4:4 pixel.
  logic [7:0] y2_q, y2_d, cb2_q, cb2_d, cr2_q, cr2_d;
  logic [7:0] partner_c;

  // Stage 3: products. Stage 4: per-channel sums. 20-bit signed covers every input.
  logic signed [19:0] yd, cbd, crd;
  logic signed [19:0] py3_q, py3_d, pr3_q, pr3_d, pgb3_q, pgb3_d;
  logic signed [19:0] pgr3_q, pgr3_d, pb3_q, pb3_d;
  logic signed [19:0] r4_q, r4_d, g4_q, g4_d, b4_q, b4_d;

  // Stage 5: rounded, clamped, blanked output.
  logic [7:0] r5_q, r5_d, g5_q, g5_d, b5_q, b5_d;

  function automatic logic [7:0] clamp8(input logic signed [19:0] v);
    logic signed [19:0] t;
    t = (v + 20'sd128) >>> 8;
    if (t < 0)
      clamp8 = 8'd0;
    else if (t > 20'sd255)
      clamp8 = 8'd255;
    else
      clamp8 = t[7:0];
  endfunction

  // Next-state logic for the phase, the delay lines and all five datapath stages.
  always_comb begin
    ph_d = i_de ? ~ph_q : 1'b0;

    hs_d = {hs_q[3:0], i_hs};
    vs_d = {vs_q[3:0], i_vs};
    de_d = {de_q[3:0], i_de};

    y1_d    = i_y;
    c1_d    = i_c;
    even1_d = ~ph_q;

    // The sample now on the input is the partner of an even pixel in stage 1,
    // because DE is contiguous within a line. No partner (line end) means neutral.
    partner_c = i_de ? i_c : 8'd128;
    y2_d  = y1_q;
    cb2_d = cb2_q;
    cr2_d = cr2_q;
    if (de_q[0] && even1_q) begin
      if (C_FIRST_CB) begin
        cb2_d = c1_q;
        cr2_d = partner_c;
      end else begin
        cr2_d = c1_q;
        cb2_d = partner_c;
      end
    end
    // Odd pixels keep the pair loaded one cycle earlier by their even partner.

    yd  = $signed({12'd0, y2_q})  - 20'sd16;
    cbd = $signed({12'd0, cb2_q}) - 20'sd128;
    crd = $signed({12'd0, cr2_q}) - 20'sd128;
    py3_d  = yd  * 20'sd298;
    pr3_d  = crd * 20'sd409;
    pgb3_d = cbd * 20'sd100;
    pgr3_d = crd * 20'sd208;
    pb3_d  = cbd * 20'sd516;

    r4_d = py3_q + pr3_q;
    g4_d = py3_q - pgb3_q - pgr3_q;
    b4_d = py3_q + pb3_q;

    r5_d = de_q[3] ? clamp8(r4_q) : 8'd0;
    g5_d = de_q[3] ? clamp8(g4_q) : 8'd0;
    b5_d = de_q[3] ? clamp8(b4_q) : 8'd0;
  end

  // Pipeline registers; reset flushes in-flight pixels and restarts the phase.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q    <= 1'b0;
      hs_q    <= '0;
      vs_q    <= '0;
      de_q    <= '0;
      y1_q    <= '0;
      c1_q    <= '0;
      even1_q <= 1'b0;
      y2_q    <= '0;
      cb2_q   <= '0;
      cr2_q   <= '0;
      py3_q   <= '0;
      pr3_q   <= '0;
      pgb3_q  <= '0;
      pgr3_q  <= '0;
      pb3_q   <= '0;
      r4_q    <= '0;
      g4_q    <= '0;
      b4_q    <= '0;
      r5_q    <= '0;
      g5_q    <= '0;
      b5_q    <= '0;
    end else begin
      ph_q    <= ph_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      y1_q    <= y1_d;
      c1_q    <= c1_d;
      even1_q <= even1_d;
      y2_q    <= y2_d;
      cb2_q   <= cb2_d;
      cr2_q   <= cr2_d;
      py3_q   <= py3_d;
      pr3_q   <= pr3_d;
      pgb3_q  <= pgb3_d;
      pgr3_q  <= pgr3_d;
      pb3_q   <= pb3_d;
      r4_q    <= r4_d;
      g4_q    <= g4_d;
      b4_q    <= b4_d;
      r5_q    <= r5_d;
      g5_q    <= g5_d;
      b5_q    <= b5_d;
    end
  end

  assign o_hs = hs_q[4];
  assign o_vs = vs_q[4];
  assign o_de = de_q[4];
  assign o_r  = r5_q;
  assign o_g  = g5_q;
  assign o_b  = b5_q;

endmodule

// File: tb/tb_yuv422_to_rgb.sv
// Bench for yuv422_to_rgb: two instances (Cb-first and Cr-first) share one stimulus
// stream; every cycle's inputs and outputs are logged and compared against a
// line-level reference of pair replication plus the BT.601 formula.
module tb_yuv422_to_rgb;

  logic       sys_clk;
  logic       rst_n;
  logic       i_hs, i_vs, i_de;
  logic [7:0] i_y, i_c;
  logic       o_hs1, o_vs1, o_de1, o_hs0, o_vs0, o_de0;
  logic [7:0] o_r1, o_g1, o_b1, o_r0, o_g0, o_b0;

  int checks = 0;
  int errors = 0;

  bit         lhs[$], lvs[$], lde[$];
  logic [7:0] ly[$], lc[$];
  logic [26:0] lo1[$], lo0[$];

  yuv422_to_rgb #(.C_FIRST_CB(1'b1)) dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_y(i_y), .i_c(i_c),
    .o_hs(o_hs1), .o_vs(o_vs1), .o_de(o_de1), .o_r(o_r1), .o_g(o_g1), .o_b(o_b1)
  );

  yuv422_to_rgb #(.C_FIRST_CB(1'b0)) dut0 (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_y(i_y), .i_c(i_c),
    .o_hs(o_hs0), .o_vs(o_vs0), .o_de(o_de0), .o_r(o_r0), .o_g(o_g0), .o_b(o_b0)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic clear_log();
    lhs.delete(); lvs.delete(); lde.delete(); ly.delete(); lc.delete();
    lo1.delete(); lo0.delete();
  endtask

  // One pixel clock: apply inputs, let the edge take them, log inputs and outputs.
  task automatic drive(input bit hs, input bit vs, input bit de,
                       input logic [7:0] y, input logic [7:0] c);
    i_hs = hs; i_vs = vs; i_de = de; i_y = y; i_c = c;
    @(posedge sys_clk);
    #1;
    lhs.push_back(hs); lvs.push_back(vs); lde.push_back(de);
    ly.push_back(y); lc.push_back(c);
    lo1.push_back({o_hs1, o_vs1, o_de1, o_r1, o_g1, o_b1});
    lo0.push_back({o_hs0, o_vs0, o_de0, o_r0, o_g0, o_b0});
  endtask

  task automatic idle(input int n, input bit hs, input bit vs);
    for (int i = 0; i < n; i++) drive(hs, vs, 1'b0, 8'($urandom), 8'($urandom));
  endtask

  function automatic logic [7:0] sat(input int v);
    logic [7:0] r;
    if (v < 0) r = 8'd0;
    else if (v > 255) r = 8'd255;
    else r = v[7:0];
    return r;
  endfunction

  // Expected output for logged input n: find its position in the line, pair it with
  // its neighbour (or 128 if the line ends), then apply the conversion formula.
  function automatic logic [26:0] model(input int n, input bit first_cb);
    int k, f, s, cb, cr, yd, r, g, b;
    if (!lde[n]) return {lhs[n], lvs[n], 1'b0, 24'd0};
    k = 0;
    while (n - k - 1 >= 0 && lde[n - k - 1]) k++;
    if (k % 2 == 0) begin
      f = int'(lc[n]);
      s = (n + 1 < lde.size() && lde[n + 1]) ? int'(lc[n + 1]) : 128;
    end else begin
      f = int'(lc[n - 1]);
      s = int'(lc[n]);
    end
    cb = (first_cb ? f : s) - 128;
    cr = (first_cb ? s : f) - 128;
    yd = int'(ly[n]) - 16;
    r = (298 * yd + 409 * cr + 128) >>> 8;
    g = (298 * yd - 100 * cb - 208 * cr + 128) >>> 8;
    b = (298 * yd + 516 * cb + 128) >>> 8;
    return {lhs[n], lvs[n], 1'b1, sat(r), sat(g), sat(b)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    clear_log();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lo1[i] !== 27'd0 || lo0[i] !== 27'd0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got %h/%h expected 0", i, lo1[i], lo0[i]);
      end
    end
    i_de = 1'b0; i_hs = 1'b0; i_vs = 1'b0;
    #2 rst_n = 1'b1;
    clear_log();
    idle(4, 1'b0, 1'b0);
  endtask

  task automatic test_black();
    int de_cnt;
    clear_log();
    idle(2, 1'b0, 1'b0);
    idle(3, 1'b1, 1'b0);
    idle(2, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 1'b1, 8'd16, 8'd128);
    idle(2, 1'b1, 1'b1);
    idle(8, 1'b0, 1'b0);
    de_cnt = 0;
    for (int n = 0; n + 4 < lo1.size(); n++) begin
      if (lo1[n + 4][24]) de_cnt++;
      checks++;
      if (lo1[n + 4] !== model(n, 1'b1)) begin
        errors++;
        $display("FAIL black n=%0d got %h expected %h", n, lo1[n + 4], model(n, 1'b1));
      end
    end
    checks++;
    if (de_cnt != 16) begin
      errors++;
      $display("FAIL black_de_count got %0d expected 16", de_cnt);
    end
  endtask

  task automatic test_levels();
    clear_log();
    idle(2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 8'd235, 8'd128);
    idle(1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 8'd126, 8'd128);
    idle(6, 1'b0, 1'b0);
    checks++;
    if (lo1[6][23:0] !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL white got %h expected ffffff", lo1[6][23:0]);
    end
    checks++;
    if (lo1[11][23:0] !== 24'h808080) begin
      errors++;
      $display("FAIL gray got %h expected 808080", lo1[11][23:0]);
    end
    for (int n = 0; n + 4 < lo1.size(); n++) begin
      checks++;
      if (lo1[n + 4] !== model(n, 1'b1) || lo0[n + 4] !== model(n, 1'b0)) begin
        errors++;
        $display("FAIL levels n=%0d got %h/%h expected %h/%h", n, lo1[n + 4], lo0[n + 4],
                 model(n, 1'b1), model(n, 1'b0));
      end
    end
  endtask

  task automatic test_red_pair();
    clear_log();
    idle(2, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'd81, 8'd90);
    drive(1'b0, 1'b0, 1'b1, 8'd81, 8'd240);
    idle(6, 1'b0, 1'b0);
    for (int n = 6; n < 8; n++) begin
      checks++;
      if (lo1[n][23:0] !== 24'hFF0000) begin
        errors++;
        $display("FAIL red_cbfirst px=%0d got %h expected ff0000", n - 6, lo1[n][23:0]);
      end
    end
    clear_log();
    idle(2, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'd81, 8'd240);
    drive(1'b0, 1'b0, 1'b1, 8'd81, 8'd90);
    idle(6, 1'b0, 1'b0);
    for (int n = 6; n < 8; n++) begin
      checks++;
      if (lo0[n][23:0] !== 24'hFF0000) begin
        errors++;
        $display("FAIL red_crfirst px=%0d got %h expected ff0000", n - 6, lo0[n][23:0]);
      end
    end
  endtask

  task automatic test_odd_line();
    clear_log();
    idle(2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 8'd81, (i % 2 == 0) ? 8'd90 : 8'd240);
    idle(1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'd81, 8'd90);
    drive(1'b0, 1'b0, 1'b1, 8'd81, 8'd240);
    idle(6, 1'b0, 1'b0);
    for (int n = 6; n < 10; n++) begin
      checks++;
      if (lo1[n][23:0] !== 24'hFF0000) begin
        errors++;
        $display("FAIL odd_pairs px=%0d got %h expected ff0000", n - 6, lo1[n][23:0]);
      end
    end
    checks++;
    if (lo1[10][23:0] !== 24'h4C5B00) begin
      errors++;
      $display("FAIL odd_last got %h expected 4c5b00", lo1[10][23:0]);
    end
    for (int n = 12; n < 14; n++) begin
      checks++;
      if (lo1[n][23:0] !== 24'hFF0000) begin
        errors++;
        $display("FAIL next_line px=%0d got %h expected ff0000", n - 12, lo1[n][23:0]);
      end
    end
    for (int n = 0; n + 4 < lo1.size(); n++) begin
      checks++;
      if (lo1[n + 4] !== model(n, 1'b1) || lo0[n + 4] !== model(n, 1'b0)) begin
        errors++;
        $display("FAIL odd_model n=%0d got %h/%h expected %h/%h", n, lo1[n + 4], lo0[n + 4],
                 model(n, 1'b1), model(n, 1'b0));
      end
    end
  endtask

  task automatic test_reset_midline();
    clear_log();
    idle(2, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b1, 8'd235, 8'd128);
    idle(1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 8'd200, 8'd60);
    drive(1'b1, 1'b1, 1'b1, 8'd200, 8'd200);
    checks++;
    if (o_de1 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_de got %b expected 1", o_de1);
    end
    i_y = 8'd50; i_c = 8'd70;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_hs1, o_vs1, o_de1, o_r1, o_g1, o_b1} !== 27'd0 ||
        {o_hs0, o_vs0, o_de0, o_r0, o_g0, o_b0} !== 27'd0) begin
      errors++;
      $display("FAIL async_reset got %h/%h expected 0",
               {o_hs1, o_vs1, o_de1, o_r1, o_g1, o_b1}, {o_hs0, o_vs0, o_de0, o_r0, o_g0, o_b0});
    end
    i_de = 1'b0; i_hs = 1'b0; i_vs = 1'b0;
    @(posedge sys_clk);
    #1 rst_n = 1'b1;
    clear_log();
    idle(8, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
    idle(6, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (lo1[n] !== 27'd0 || lo0[n] !== 27'd0) begin
        errors++;
        $display("FAIL stale_after_reset cyc=%0d got %h/%h expected 0", n, lo1[n], lo0[n]);
      end
    end
    for (int n = 0; n + 4 < lo1.size(); n++) begin
      checks++;
      if (lo1[n + 4] !== model(n, 1'b1) || lo0[n + 4] !== model(n, 1'b0)) begin
        errors++;
        $display("FAIL post_reset n=%0d got %h/%h expected %h/%h", n, lo1[n + 4], lo0[n + 4],
                 model(n, 1'b1), model(n, 1'b0));
      end
    end
  endtask

  task automatic test_random();
    bit vs;
    int len, gap;
    clear_log();
    idle(2, 1'b0, 1'b0);
    vs = 1'b0;
    for (int line = 0; line < 1000; line++) begin
      if (line % 37 == 0) vs = ~vs;
      gap = $urandom_range(1, 4);
      len = $urandom_range(1, 24);
      for (int i = 0; i < gap; i++)
        drive(1'($urandom), vs, 1'b0, 8'($urandom), 8'($urandom));
      for (int i = 0; i < len; i++)
        drive(1'($urandom), vs, 1'b1, 8'($urandom), 8'($urandom));
    end
    idle(6, 1'b0, 1'b0);
    for (int n = 0; n + 4 < lo1.size(); n++) begin
      checks++;
      if (lo1[n + 4] !== model(n, 1'b1)) begin
        errors++;
        $display("FAIL random_cbfirst n=%0d got %h expected %h", n, lo1[n + 4], model(n, 1'b1));
      end
      checks++;
      if (lo0[n + 4] !== model(n, 1'b0)) begin
        errors++;
        $display("FAIL random_crfirst n=%0d got %h expected %h", n, lo0[n + 4], model(n, 1'b0));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0; i_y = 8'd0; i_c = 8'd0;
    #3;
    test_reset();
    test_black();
    test_levels();
    test_red_pair();
    test_odd_line();
    test_reset_midline();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
